// File: rtl/decoder_sweep_pkg.sv
// Shared types and MISR arithmetic for the SM83 decoder opcode-sweep engine.
package decoder_sweep_pkg;

  localparam int unsigned SIG_W = 32;
  localparam logic [SIG_W-1:0] POLY = 32'h04C11DB7;
  localparam logic [SIG_W-1:0] SEED = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StWait,
    StSample,
    StEmit,
    StDone
  } state_t;

  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                 input logic [SIG_W-1:0] v);
    return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? POLY : '0) ^ v;
  endfunction

endpackage

// File: rtl/decoder_sweep_misr.sv
// 32-bit MISR with synchronous clear to SEED; a DW-bit input is XOR-folded to 32 bits per step.
module sweep_misr
  import decoder_sweep_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic             CLK,
  input  logic             nRESET,
  input  logic             clr,
  input  logic             en,
  input  logic [DW-1:0]    din,
  output logic [SIG_W-1:0] sig
);

  localparam int unsigned NCHUNK = (DW + SIG_W - 1) / SIG_W;

  logic [NCHUNK*SIG_W-1:0] padded;
  logic [SIG_W-1:0]        folded;
  logic [SIG_W-1:0]        sig_q;

  always_comb begin
    padded         = '0;
    padded[DW-1:0] = din;
    folded         = '0;
    for (int i = 0; i < int'(NCHUNK); i++) begin
      folded = folded ^ padded[i*SIG_W +: SIG_W];
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      sig_q <= '0;
    end else if (clr) begin
      sig_q <= SEED;
    end else if (en) begin
      sig_q <= misr_step(sig_q, folded);
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/decoder_sweep.sv
// Opcode-sweep engine: drives Decoder1/2/3 inputs over an opcode range and every phase,
// compacting decoder outputs into per-opcode and whole-run MISR signatures.
module decoder_sweep
  import decoder_sweep_pkg::*;
#(
  parameter logic [7:0]  FIRST  = 8'h00,
  parameter logic [7:0]  LAST   = 8'hFF,
  parameter int unsigned PH_W   = 2,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned DW     = 217
) (
  input  logic             CLK,
  input  logic             nRESET,
  input  logic             start,
  input  logic             cb,
  input  logic             seq_a3,
  output logic [7:0]       ir,
  output logic [25:0]      a,
  input  logic [DW-1:0]    dec,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [7:0]       rec_ir,
  output logic [SIG_W-1:0] rec_sig,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] run_sig
);

  localparam int unsigned       WCNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [PH_W-1:0]   PH_MAX    = '1;
  localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'(SETTLE - 1);

  state_t            state_q, state_d;
  logic [7:0]        ir_q, ir_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              cb_q, cb_d, a3_q, a3_d;
  logic              sig_clr, sig_en, run_clr, run_en;
  logic [SIG_W-1:0]  op_sig, run_acc;
  logic [2:0]        ph3;
  logic [25:0]       tbits;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    phase_d = phase_q;
    wcnt_d  = wcnt_q;
    cb_d    = cb_q;
    a3_d    = a3_q;
    sig_clr = 1'b0;
    sig_en  = 1'b0;
    run_clr = 1'b0;
    run_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        ir_d    = FIRST;
        phase_d = '0;
        if (start) begin
          cb_d    = cb;
          a3_d    = seq_a3;
          sig_clr = 1'b1;
          run_clr = 1'b1;
          state_d = StDrive;
        end
      end
      StDrive: begin
        if (SETTLE > 1) begin
          wcnt_d  = WCNT_INIT;
          state_d = StWait;
        end else begin
          state_d = StSample;
        end
      end
      StWait: begin
        wcnt_d = wcnt_q - WCNT_W'(1);
        if (wcnt_q == WCNT_W'(1)) state_d = StSample;
      end
      StSample: begin
        sig_en = 1'b1;
        if (phase_q != PH_MAX) begin
          phase_d = phase_q + PH_W'(1);
          state_d = StDrive;
        end else begin
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (rec_ready) begin
          run_en = 1'b1;
          if (ir_q == LAST) begin
            state_d = StDone;
          end else begin
            ir_d    = ir_q + 8'd1;
            phase_d = '0;
            sig_clr = 1'b1;
            state_d = StDrive;
          end
        end
      end
      StDone: begin
        // Return to IDLE already presenting FIRST so the idle outputs match reset.
        if (!start) begin
          ir_d    = FIRST;
          phase_d = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= StIdle;
      ir_q    <= FIRST;
      phase_q <= '0;
      wcnt_q  <= '0;
      cb_q    <= 1'b0;
      a3_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      phase_q <= phase_d;
      wcnt_q  <= wcnt_d;
      cb_q    <= cb_d;
      a3_q    <= a3_d;
    end
  end

  sweep_misr #(
    .DW(DW)
  ) u_op_misr (
    .CLK   (CLK),
    .nRESET(nRESET),
    .clr   (sig_clr),
    .en    (sig_en),
    .din   (dec),
    .sig   (op_sig)
  );

  sweep_misr #(
    .DW(SIG_W)
  ) u_run_misr (
    .CLK   (CLK),
    .nRESET(nRESET),
    .clr   (run_clr),
    .en    (run_en),
    .din   (op_sig),
    .sig   (run_acc)
  );

  assign ph3 = 3'(phase_q);

  always_comb begin
    tbits    = '0;
    tbits[1] = cb_q;
    tbits[3] = a3_q;
    for (int i = 0; i < 8; i++) tbits[5 + 2*i] = ir_q[7 - i];
    for (int i = 0; i < 3; i++) tbits[20 + 2*i] = ph3[i];
  end

  // Below a[20] the odd line is true and the even line its complement; above, the reverse.
  always_comb begin
    a = tbits;
    for (int k = 0; k < 20; k += 2) a[k] = ~tbits[k + 1];
    for (int k = 21; k < 26; k += 2) a[k] = ~tbits[k - 1];
  end

  assign ir        = ir_q;
  assign rec_valid = (state_q == StEmit);
  assign rec_ir    = rec_valid ? ir_q : 8'h00;
  assign rec_sig   = rec_valid ? op_sig : '0;
  assign busy      = (state_q != StIdle) && (state_q != StDone);
  assign done      = (state_q == StDone);
  assign run_sig   = run_acc;

endmodule

// File: doc/decoder_sweep.md
# decoder_sweep

Synthesizable opcode-sweep engine for the SM83 instruction decoder chain (Decoder1/2/3). It replaces the free-running testbench counter and mock sequencer with a controllable sweep over an opcode range and every sequencer phase per opcode. It compacts the concatenated decoder outputs into one 32-bit MISR signature per opcode, plus a whole-run signature. It sits between a host/bench controller and the decoder instances, and streams per-opcode records over a valid/ready port.

## Interface
- `FIRST`, default 8'h00: first opcode of the sweep.
- `LAST`, default 8'hFF: last opcode of the sweep (inclusive; wraps modulo 256).
- `PH_W`, default 2: phase bits per opcode (1..3), giving 2^PH_W phases.
- `SETTLE`, default 1: cycles between driving `a`/`ir` and sampling `dec` (≥1).
- `DW`, default 217: width of the decoder observation bus, {x[68:0], w[40:0], d[106:0]}.
- `CLK  in  1`: clock; all state on rising edge.
- `nRESET  in  1`: asynchronous, active-low reset.
- `start  in  1`: level; in IDLE, a high level launches a sweep.
- `cb  in  1`: drives a[1]; sampled at launch and held for the whole sweep.
- `seq_a3  in  1`: drives a[3]; sampled at launch and held for the whole sweep.
- `ir  out  8`: opcode to Decoder2/3 (`nIR` = ~ir is external).
- `a  out  26`: Decoder1 input vector.
- `dec  in  DW`: decoder outputs.
- `rec_valid  out  1`, `rec_ready  in  1`: per-opcode record handshake.
- `rec_ir  out  8`, `rec_sig  out  32`: record payload.
- `busy  out  1`: high in any state other than IDLE and DONE.
- `done  out  1`: high in DONE.
- `run_sig  out  32`: whole-run signature; valid in DONE.

## Operation
- `a` mapping:
  - a[1]=cb_q, a[3]=a3_q.
  - a[5,7,9,11,13,15,17,19] = ir[7..0].
  - a[20,22,24] = phase[0..2]; bits above PH_W−1 read as 0.
  - Every even index k in 0..18 carries ~a[k+1]; a[21,23,25] = ~a[20,22,24].
- FSM states: IDLE, DRIVE, WAIT, SAMPLE, EMIT, DONE.
  - IDLE: ir=FIRST, phase=0, outputs idle. On start=1: latch cb/seq_a3, sig←32'hFFFFFFFF, run←32'hFFFFFFFF, go to DRIVE.
  - DRIVE: present ir/phase (registered outputs). Go to WAIT with wcnt=SETTLE−1, or straight to SAMPLE when SETTLE=1.
  - WAIT: count wcnt down to 0, then go to SAMPLE.
  - SAMPLE: sig←step(sig, fold(dec)).
    - If phase ≠ max: phase+1, go to DRIVE.
    - Otherwise go to EMIT.
  - EMIT: rec_valid=1, rec_ir=ir, rec_sig=sig, all held stable until rec_ready. On transfer:
    - run←step(run, sig).
    - If ir==LAST, go to DONE.
    - Otherwise ir+1 (mod 256), phase←0, sig←seed, go to DRIVE.
  - DONE: done=1, run_sig valid. Leaves to IDLE only when start=0.
- step(s, v) = {s[30:0],1'b0} ^ (s[31] ? 32'h04C11DB7 : 0) ^ v.
- fold(dec): zero-pad dec to a multiple of 32 bits, then XOR all 32-bit chunks. Chunk 0 is dec[31:0].
- Wrap: the sweep covers ((LAST−FIRST) mod 256)+1 opcodes. FIRST==LAST is exactly one opcode. FIRST=FE, LAST=01 is FE,FF,00,01.
- start is ignored outside IDLE and DONE. Changes to cb/seq_a3 mid-sweep have no effect.
- rec_ready high outside EMIT is ignored. rec_ready high on EMIT entry transfers in that same cycle.

## Timing
- Reset values: ir=FIRST, a per the mapping with ir=FIRST, cb=0, a3=0, phase=0.
- Reset values: rec_valid=0, rec_ir=0, rec_sig=0, busy=0, done=0, run_sig=0.
- nRESET low at any point aborts the sweep immediately. No partial record is emitted; rec_valid drops asynchronously.
- Per opcode, with rec_ready tied high: 2^PH_W·(SETTLE+1)+1 cycles. Default is 9.
- Launch latency: start sampled in IDLE; DRIVE is the next cycle; the first record appears after one opcode period.
- Stall: each cycle rec_ready is low in EMIT adds exactly one cycle. No opcode is skipped or repeated.

## Structure
- Package `decoder_sweep_pkg` holds:
  - SIG_W=32, POLY=32'h04C11DB7, SEED=32'hFFFFFFFF.
  - The state enum.
  - Function `misr_step`.
- Sub-module `sweep_misr`: 32-bit register with clear/enable and a generic DW-bit fold input. Instantiated twice: per-opcode and run.

## Test plan
- FIRST=LAST=8'h00, PH_W=1 forced to one phase via bench model, dec=0 → rec_sig for one phase = 32'hFB3EE249.
- Default params, dec from real Decoder1/2/3 → 256 records, rec_ir 00..FF in order, each rec_sig matching the bench reference model; run_sig matches the model.
- FIRST=FE, LAST=01 → exactly 4 records FE,FF,00,01, then done=1.
- rec_ready held low 5 cycles in the second EMIT → record fields stable throughout; total time +5 cycles; no duplicate record.
- nRESET pulsed low mid-WAIT → all outputs at reset values; a fresh start reproduces the identical run_sig.
- SETTLE=3, PH_W=3 → 8 phases × 4 cycles + 1 = 33 cycles per opcode; a[20/22/24] step 0..7.
